// File: rtl/alu_arbiter_if.sv
// Request/response and ALU-side signal bundle for alu_arbiter.
// The slave modport is the arbiter's view; master is the requesters' and ALU's view.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             i_req0_valid;
  logic             o_req0_ready;
  logic [4:0]       i_req0_ctrl;
  logic [WIDTH-1:0] i_req0_a;
  logic [WIDTH-1:0] i_req0_b;
  logic             o_rsp0_valid;
  logic             i_rsp0_ready;
  logic [WIDTH-1:0] o_rsp0_result;
  logic             o_rsp0_equal;

  logic             i_req1_valid;
  logic             o_req1_ready;
  logic [4:0]       i_req1_ctrl;
  logic [WIDTH-1:0] i_req1_a;
  logic [WIDTH-1:0] i_req1_b;
  logic             o_rsp1_valid;
  logic             i_rsp1_ready;
  logic [WIDTH-1:0] o_rsp1_result;
  logic             o_rsp1_equal;

  logic [4:0]       o_alu_ctrl;
  logic [WIDTH-1:0] o_alu_a;
  logic [WIDTH-1:0] o_alu_b;
  logic [WIDTH-1:0] i_alu_result;
  logic             i_alu_equal;
  logic             o_busy;

  modport slave (
    input  i_req0_valid, i_req0_ctrl, i_req0_a, i_req0_b, i_rsp0_ready,
    output o_req0_ready, o_rsp0_valid, o_rsp0_result, o_rsp0_equal,
    input  i_req1_valid, i_req1_ctrl, i_req1_a, i_req1_b, i_rsp1_ready,
    output o_req1_ready, o_rsp1_valid, o_rsp1_result, o_rsp1_equal,
    output o_alu_ctrl, o_alu_a, o_alu_b, o_busy,
    input  i_alu_result, i_alu_equal
  );

  modport master (
    output i_req0_valid, i_req0_ctrl, i_req0_a, i_req0_b, i_rsp0_ready,
    input  o_req0_ready, o_rsp0_valid, o_rsp0_result, o_rsp0_equal,
    output i_req1_valid, i_req1_ctrl, i_req1_a, i_req1_b, i_rsp1_ready,
    input  o_req1_ready, o_rsp1_valid, o_rsp1_result, o_rsp1_equal,
    input  o_alu_ctrl, o_alu_a, o_alu_b, o_busy,
    output i_alu_result, i_alu_equal
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of the shared combinational EX-stage ALU:
// grant, run one op per IDLE->EXEC->RESP round, hold the sanitised result until accepted.
module alu_arbiter #(
  parameter int WIDTH     = 32,
  parameter int PRIO_MODE = 0
) (
  input logic          i_clk,
  input logic          i_rst_n,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_r;
  logic [4:0]       op_ctrl_r;
  logic [WIDTH-1:0] op_a_r;
  logic [WIDTH-1:0] op_b_r;
  logic             owner_r;
  logic             last_grant_r;
  logic             busy_r;
  logic             rsp0_valid_r;
  logic             rsp1_valid_r;
  logic [WIDTH-1:0] rsp0_result_r;
  logic [WIDTH-1:0] rsp1_result_r;
  logic             rsp0_equal_r;
  logic             rsp1_equal_r;

  logic             grant0_s;
  logic             grant1_s;
  logic             accept_s;
  logic [WIDTH-1:0] result_s;
  logic             equal_s;

  // Codes whose ALU result is meaningless (branches, reserved, undefined) report 0.
  function automatic logic result_zeroed(input logic [4:0] ctrl);
    return ((ctrl >= 5'd10) && (ctrl <= 5'd15)) || (ctrl >= 5'd17);
  endfunction

  // Only compare/branch codes carry a meaningful equal flag.
  function automatic logic equal_kept(input logic [4:0] ctrl);
    return (ctrl == 5'd7) || (ctrl == 5'd8) || ((ctrl >= 5'd10) && (ctrl <= 5'd15));
  endfunction

  // Arbitration: a tie goes to port 0 in fixed mode, otherwise to the port not served last.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (bus.i_req0_valid && bus.i_req1_valid) begin
      if ((PRIO_MODE != 0) || last_grant_r) begin
        grant0_s = 1'b1;
      end else begin
        grant1_s = 1'b1;
      end
    end else begin
      grant0_s = bus.i_req0_valid;
      grant1_s = bus.i_req1_valid;
    end
  end

  // Result/flag sanitising and owner-side response acceptance.
  always_comb begin
    result_s = result_zeroed(op_ctrl_r) ? {WIDTH{1'b0}} : bus.i_alu_result;
    equal_s  = equal_kept(op_ctrl_r) ? bus.i_alu_equal : 1'b0;
    accept_s = owner_r ? bus.i_rsp1_ready : bus.i_rsp0_ready;
  end

  assign bus.o_req0_ready  = (state_r == IDLE) && grant0_s;
  assign bus.o_req1_ready  = (state_r == IDLE) && grant1_s;
  assign bus.o_alu_ctrl    = op_ctrl_r;
  assign bus.o_alu_a       = op_a_r;
  assign bus.o_alu_b       = op_b_r;
  assign bus.o_busy        = busy_r;
  assign bus.o_rsp0_valid  = rsp0_valid_r;
  assign bus.o_rsp0_result = rsp0_result_r;
  assign bus.o_rsp0_equal  = rsp0_equal_r;
  assign bus.o_rsp1_valid  = rsp1_valid_r;
  assign bus.o_rsp1_result = rsp1_result_r;
  assign bus.o_rsp1_equal  = rsp1_equal_r;

  // Control FSM; response registers stay 0 outside RESP so idle ports never show stale data.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r       <= IDLE;
      op_ctrl_r     <= 5'd0;
      op_a_r        <= {WIDTH{1'b0}};
      op_b_r        <= {WIDTH{1'b0}};
      owner_r       <= 1'b0;
      last_grant_r  <= 1'b1;
      busy_r        <= 1'b0;
      rsp0_valid_r  <= 1'b0;
      rsp1_valid_r  <= 1'b0;
      rsp0_result_r <= {WIDTH{1'b0}};
      rsp1_result_r <= {WIDTH{1'b0}};
      rsp0_equal_r  <= 1'b0;
      rsp1_equal_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant0_s || grant1_s) begin
            op_ctrl_r    <= grant1_s ? bus.i_req1_ctrl : bus.i_req0_ctrl;
            op_a_r       <= grant1_s ? bus.i_req1_a : bus.i_req0_a;
            op_b_r       <= grant1_s ? bus.i_req1_b : bus.i_req0_b;
            owner_r      <= grant1_s;
            last_grant_r <= grant1_s;
            busy_r       <= 1'b1;
            state_r      <= EXEC;
          end else begin
            state_r      <= IDLE;
          end
        end
        EXEC: begin
          rsp0_valid_r  <= ~owner_r;
          rsp1_valid_r  <= owner_r;
          rsp0_result_r <= owner_r ? {WIDTH{1'b0}} : result_s;
          rsp1_result_r <= owner_r ? result_s : {WIDTH{1'b0}};
          rsp0_equal_r  <= ~owner_r & equal_s;
          rsp1_equal_r  <= owner_r & equal_s;
          state_r       <= RESP;
        end
        RESP: begin
          if (accept_s) begin
            rsp0_valid_r  <= 1'b0;
            rsp1_valid_r  <= 1'b0;
            rsp0_result_r <= {WIDTH{1'b0}};
            rsp1_result_r <= {WIDTH{1'b0}};
            rsp0_equal_r  <= 1'b0;
            rsp1_equal_r  <= 1'b0;
            busy_r        <= 1'b0;
            state_r       <= IDLE;
          end else begin
            state_r       <= RESP;
          end
        end
        default: begin
          rsp0_valid_r <= 1'b0;
          rsp1_valid_r <= 1'b0;
          busy_r       <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

endmodule
